// File: rtl/fft_pkg.sv
// Shared types and constants for the 8-point FFT twiddle sequencer.
// Holds the W8 table values, FSM state type and result tag layout.
package fft_pkg;

    localparam logic [31:0] W8_ONE      = 32'h3F800000;
    localparam logic [31:0] W8_NEG_ONE  = 32'hBF800000;
    localparam logic [31:0] W8_RT_HALF  = 32'h3F3504F3;
    localparam logic [31:0] W8_NRT_HALF = 32'hBF3504F3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [1:0] stage;
        logic [1:0] bf;
    } tw_tag_t;

    // One slot of the result-alignment delay line
    typedef struct packed {
        logic    tag_v;
        logic    shadow_v;
        logic    is_mj;
        tw_tag_t tag;
    } dl_t;

    function automatic int l_mw_f(input int l_mul, input int l_add);
        return l_mul + l_add;
    endfunction

endpackage

// File: rtl/dffr.sv
// Plain register with asynchronous active-low clear.
// Every state element in the sequencer is built from this cell.
module dffr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= d;
    end

endmodule

// File: rtl/twiddle_rom8.sv
// W8^k lookup in IEEE-754 single precision.
// is_mj marks k=2, where the multiply reduces to a -j rotation.
module twiddle_rom8
    import fft_pkg::*;
(
    input  logic [1:0]  k,
    output logic [31:0] w_re,
    output logic [31:0] w_im,
    output logic        is_mj
);

    always_comb begin
        w_re  = W8_ONE;
        w_im  = '0;
        is_mj = 1'b0;
        unique case (k)
            2'd0: begin
                w_re = W8_ONE;
                w_im = '0;
            end
            2'd1: begin
                w_re = W8_RT_HALF;
                w_im = W8_NRT_HALF;
            end
            2'd2: begin
                w_re  = '0;
                w_im  = W8_NEG_ONE;
                is_mj = 1'b1;
            end
            2'd3: begin
                w_re = W8_NRT_HALF;
                w_im = W8_NRT_HALF;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fft8_twiddle_sched.sv
// Stage/butterfly sequencer for the 8-point radix-2 DIT twiddle stage.
// Issues operand reads, feeds the twiddle pipe, aligns select and tag.
module fft8_twiddle_sched
    import fft_pkg::*;
#(
    parameter int L_MUL = 3,
    parameter int L_ADD = 2,
    parameter int L_BF  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        rd_en,
    output logic [2:0]  rd_addr,
    output logic        tp_valid_in,
    output logic [31:0] tp_w_re,
    output logic [31:0] tp_w_im,
    output logic        tp_is_mj,
    input  logic        tp_valid_out,
    output logic        tag_valid,
    output logic [1:0]  tag_stage,
    output logic [1:0]  tag_bf,
    output logic        err_align
);

    localparam int L_MW    = l_mw_f(L_MUL, L_ADD);
    localparam int CW      = 8;
    localparam int D_BAR   = 1 + L_MW + L_BF;
    localparam int D_FLUSH = 1 + L_MW;
    localparam int TPW     = 1 + 32 + 32 + 1 + 4;
    localparam int DLW     = $bits(dl_t);

    state_t         state;
    state_t         state_nx;
    logic [2:0]     state_raw;
    logic [1:0]     s_q, s_nx;
    logic [1:0]     j_q, j_nx;
    logic [CW-1:0]  cnt_q, cnt_nx;
    logic           flush;

    dffr #(.W(3)) u_state (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (state_nx),
        .q     (state_raw)
    );
    assign state = state_t'(state_raw);

    dffr #(.W(4 + CW)) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({s_nx, j_nx, cnt_nx}),
        .q     ({s_q, j_q, cnt_q})
    );

    always_comb begin
        state_nx = state;
        s_nx     = s_q;
        j_nx     = j_q;
        cnt_nx   = cnt_q;
        rd_en    = 1'b0;
        done     = 1'b0;
        flush    = abort && (state == ST_ISSUE ||
                             state == ST_DRAIN ||
                             state == ST_DONE);
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_ISSUE;
                    s_nx     = 2'd0;
                    j_nx     = 2'd0;
                end
            end
            ST_ISSUE: begin
                rd_en = 1'b1;
                j_nx  = j_q + 2'd1;
                if (j_q == 2'd3) begin
                    state_nx = ST_DRAIN;
                    cnt_nx   = CW'(D_BAR);
                end
            end
            ST_DRAIN: begin
                cnt_nx = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    if (s_q == 2'd2) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_ISSUE;
                        s_nx     = s_q + 2'd1;
                        j_nx     = 2'd0;
                    end
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            ST_FLUSH: begin
                cnt_nx = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        // Cancel wins over whatever the state would have done this cycle
        if (flush) begin
            state_nx = ST_FLUSH;
            cnt_nx   = CW'(D_FLUSH);
            rd_en    = 1'b0;
            done     = 1'b0;
        end
    end

    assign busy = (state != ST_IDLE);

    logic [2:0] half, pos, grp, top, k_w, addr_c;
    logic [1:0] k;

    // Bit-reversed input: bottom operand sits half above the top one
    always_comb begin
        half   = 3'd1 << s_q;
        pos    = {1'b0, j_q} & (half - 3'd1);
        grp    = {1'b0, j_q} >> s_q;
        top    = (grp << (s_q + 2'd1)) + pos;
        addr_c = top + half;
        k_w    = pos << (2'd2 - s_q);
        k      = k_w[1:0];
    end

    assign rd_addr = rd_en ? addr_c : 3'd0;

    logic [31:0] rom_re, rom_im;
    logic        rom_mj;

    twiddle_rom8 u_rom (
        .k     (k),
        .w_re  (rom_re),
        .w_im  (rom_im),
        .is_mj (rom_mj)
    );

    logic [TPW-1:0] tp_d, tp_q;
    logic           mj_s0;
    tw_tag_t        tag_s0;

    assign tp_d = {rd_en,
                   rd_en ? rom_re : 32'd0,
                   rd_en ? rom_im : 32'd0,
                   rd_en & rom_mj,
                   s_q, j_q};

    dffr #(.W(TPW)) u_tp (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tp_d),
        .q     (tp_q)
    );
    assign {tp_valid_in, tp_w_re, tp_w_im, mj_s0, tag_s0} = tp_q;

    dl_t dl [0:L_MW];

    assign dl[0] = '{tag_v:    tp_valid_in,
                     shadow_v: tp_valid_in,
                     is_mj:    mj_s0,
                     tag:      tag_s0};

    // Shadow valid keeps tracking the pipe through an abort; tag_v does not
    for (genvar i = 0; i < L_MW; i++) begin : g_dl
        dl_t d_i;
        always_comb begin
            d_i = dl[i];
            if (flush) d_i.tag_v = 1'b0;
        end
        dffr #(.W(DLW)) u_ff (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (d_i),
            .q     (dl[i+1])
        );
    end

    assign tag_valid = dl[L_MW].tag_v;
    assign tag_stage = dl[L_MW].tag.stage;
    assign tag_bf    = dl[L_MW].tag.bf;
    assign tp_is_mj  = dl[L_MW].is_mj;

    dffr #(.W(1)) u_err (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (err_align | (tp_valid_out != dl[L_MW].shadow_v)),
        .q     (err_align)
    );

endmodule

// File: tb/tb_fft8_twiddle_sched.sv
// Directed bench for the FFT8 twiddle sequencer.
// Two instances: default latencies and L_MUL=4/L_ADD=3.
module tb_fft8_twiddle_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a, abort_a, start_b, abort_b, kill_b;

    logic        busy_a, done_a, rd_en_a, tpv_a, mj_a, tagv_a, err_a;
    logic [2:0]  rd_addr_a;
    logic [31:0] wre_a, wim_a;
    logic [1:0]  tst_a, tbf_a;
    logic        tvo_a;

    logic        busy_b, done_b, rd_en_b, tpv_b, mj_b, tagv_b, err_b;
    logic [2:0]  rd_addr_b;
    logic [31:0] wre_b, wim_b;
    logic [1:0]  tst_b, tbf_b;
    logic        tvo_b;

    logic [4:0] pa;
    logic [6:0] pb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pa <= '0;
            pb <= '0;
        end else begin
            pa <= {pa[3:0], tpv_a};
            pb <= {pb[5:0], tpv_b};
        end
    end

    assign tvo_a = pa[4];
    assign tvo_b = pb[6] & ~kill_b;

    fft8_twiddle_sched u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start_a),
        .abort        (abort_a),
        .busy         (busy_a),
        .done         (done_a),
        .rd_en        (rd_en_a),
        .rd_addr      (rd_addr_a),
        .tp_valid_in  (tpv_a),
        .tp_w_re      (wre_a),
        .tp_w_im      (wim_a),
        .tp_is_mj     (mj_a),
        .tp_valid_out (tvo_a),
        .tag_valid    (tagv_a),
        .tag_stage    (tst_a),
        .tag_bf       (tbf_a),
        .err_align    (err_a)
    );

    fft8_twiddle_sched #(.L_MUL(4), .L_ADD(3), .L_BF(2)) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start_b),
        .abort        (abort_b),
        .busy         (busy_b),
        .done         (done_b),
        .rd_en        (rd_en_b),
        .rd_addr      (rd_addr_b),
        .tp_valid_in  (tpv_b),
        .tp_w_re      (wre_b),
        .tp_w_im      (wim_b),
        .tp_is_mj     (mj_b),
        .tp_valid_out (tvo_b),
        .tag_valid    (tagv_b),
        .tag_stage    (tst_b),
        .tag_bf       (tbf_b),
        .err_align    (err_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rng(input int a, input int b);
        logic [63:0] v;
        v = '0;
        for (int i = a; i <= b; i++) v[i] = 1'b1;
        return v;
    endfunction

    logic [63:0] rd_v, tpv_v, tagv_v, done_v, busy_v, rdb_v, doneb_v;
    logic [2:0]  addr_q [$];
    logic [31:0] wre_q [$];
    logic [31:0] wim_q [$];
    int          mj_hits, mj_bad;

    task automatic frame(input bit use_b, input int ncyc, input int abort_at,
                         input int restart_at, input int kill_at);
        logic exp_mj;
        rd_v = '0; tpv_v = '0; tagv_v = '0; done_v = '0; busy_v = '0;
        rdb_v = '0; doneb_v = '0;
        addr_q.delete(); wre_q.delete(); wim_q.delete();
        mj_hits = 0; mj_bad = 0;
        @(negedge clk);
        start_a = !use_b;
        start_b = use_b;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start_a = !use_b && (c == restart_at);
            start_b = use_b && (c == restart_at);
            abort_a = !use_b && (c == abort_at);
            kill_b  = (c == kill_at);
            #1;
            rd_v[c]    = rd_en_a;
            tpv_v[c]   = tpv_a;
            tagv_v[c]  = tagv_a;
            done_v[c]  = done_a;
            busy_v[c]  = busy_a;
            rdb_v[c]   = rd_en_b;
            doneb_v[c] = done_b;
            if (rd_en_a) addr_q.push_back(rd_addr_a);
            if (tpv_a) begin
                wre_q.push_back(wre_a);
                wim_q.push_back(wim_a);
            end
            if (tagv_a) begin
                exp_mj = (tst_a == 2'd1 && tbf_a[0]) ||
                         (tst_a == 2'd2 && tbf_a == 2'd2);
                if (mj_a != exp_mj) mj_bad++;
                if (tst_a == 2'd1 && tbf_a == 2'd1 && mj_a && tvo_a)
                    mj_hits++;
            end
        end
        start_a = 0; start_b = 0; abort_a = 0; kill_b = 0;
    endtask

    int          addr_exp [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int          k_exp    [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    logic [31:0] re_tab   [4]  = '{32'h3F800000, 32'h3F3504F3,
                                   32'h00000000, 32'hBF3504F3};
    logic [31:0] im_tab   [4]  = '{32'h00000000, 32'hBF3504F3,
                                   32'hBF800000, 32'hBF3504F3};

    initial begin
        logic [63:0] g;
        rst_n = 0;
        start_a = 0; abort_a = 0; start_b = 0; abort_b = 0; kill_b = 0;
        repeat (3) @(negedge clk);
        check_eq("reset_outs_a", 64'(|{busy_a, done_a, rd_en_a, rd_addr_a,
                 tpv_a, wre_a, wim_a, mj_a, tagv_a, tst_a, tbf_a, err_a}), 0);
        check_eq("reset_outs_b", 64'(|{busy_b, done_b, rd_en_b, rd_addr_b,
                 tpv_b, wre_b, wim_b, mj_b, tagv_b, tst_b, tbf_b, err_b}), 0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // Reset in the middle of stage 1
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        repeat (14) @(negedge clk);
        check_eq("mid_busy_before_rst", 64'(busy_a), 1);
        check_eq("mid_rden_before_rst", 64'(rd_en_a), 1);
        rst_n = 0;
        #1;
        check_eq("mid_rst_outs", 64'(|{busy_a, done_a, rd_en_a, rd_addr_a,
                 tpv_a, wre_a, wim_a, mj_a, tagv_a, tst_a, tbf_a, err_a}), 0);
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // Full frame at default latencies
        frame(0, 45, -1, -1, -1);
        check_eq("f_rd_en", rd_v, rng(1, 4) | rng(13, 16) | rng(25, 28));
        check_eq("f_tp_valid_in", tpv_v, rng(2, 5) | rng(14, 17) | rng(26, 29));
        check_eq("f_tag_valid", tagv_v, rng(7, 10) | rng(19, 22) | rng(31, 34));
        check_eq("f_done", done_v, rng(37, 37));
        check_eq("f_busy", busy_v, rng(1, 37));
        check_eq("f_n_addr", 64'(addr_q.size()), 12);
        check_eq("f_n_w", 64'(wre_q.size()), 12);
        for (int i = 0; i < 12; i++) begin
            g = (i < addr_q.size()) ? 64'(addr_q[i]) : 64'hDEAD;
            check_eq($sformatf("f_addr%0d", i), g, 64'(addr_exp[i]));
            g = (i < wre_q.size()) ? 64'(wre_q[i]) : 64'hDEAD;
            check_eq($sformatf("f_w_re%0d", i), g, 64'(re_tab[k_exp[i]]));
            g = (i < wim_q.size()) ? 64'(wim_q[i]) : 64'hDEAD;
            check_eq($sformatf("f_w_im%0d", i), g, 64'(im_tab[k_exp[i]]));
        end
        check_eq("f_mj_tag11_hits", 64'(mj_hits), 1);
        check_eq("f_mj_bad", 64'(mj_bad), 0);
        check_eq("f_err_align", 64'(err_a), 0);

        // Start while busy is ignored
        frame(0, 45, -1, 10, -1);
        check_eq("rs_rd_en", rd_v, rng(1, 4) | rng(13, 16) | rng(25, 28));
        check_eq("rs_done", done_v, rng(37, 37));
        check_eq("rs_n_addr", 64'(addr_q.size()), 12);

        // Abort at the second read of stage 1
        frame(0, 30, 14, -1, -1);
        check_eq("ab_rd_en", rd_v, rng(1, 4) | rng(13, 13));
        check_eq("ab_tp_valid_in", tpv_v, rng(2, 5) | rng(14, 14));
        check_eq("ab_tag_valid", tagv_v, rng(7, 10));
        check_eq("ab_busy", busy_v, rng(1, 20));
        check_eq("ab_done", done_v, 0);
        check_eq("ab_err_align", 64'(err_a), 0);

        // Longer pipe
        frame(1, 50, -1, -1, -1);
        check_eq("lp_rd_en", rdb_v, rng(1, 4) | rng(15, 18) | rng(29, 32));
        check_eq("lp_done", doneb_v, rng(43, 43));
        check_eq("lp_err_align", 64'(err_b), 0);

        // Drop one pipe valid: alignment error latches
        frame(1, 12, -1, -1, 9);
        check_eq("lp_err_set", 64'(err_b), 1);
        repeat (40) @(negedge clk);
        check_eq("lp_err_sticky", 64'(err_b), 1);
        check_eq("lp_busy_end", 64'(busy_b), 0);
        check_eq("a_err_clean", 64'(err_a), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
